// File: rtl/wb_prefetch_buf_pkg.sv
// Shared types and constants for the Wishbone BRAM prefetch buffer.
package wb_prefetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DEMAND,
    PREF,
    WRITE,
    DRAIN
  } state_t;

  localparam logic [31:0]  REGION_BASE = 32'h3800_0000;
  localparam int unsigned  WORD_INC    = 4;

  // True when the top address byte selects the claimed region.
  function automatic logic in_region(input logic [31:0] a, input logic [7:0] region);
    return a[31:24] == region;
  endfunction

endpackage

// File: rtl/wb_prefetch_buf_if.sv
// Wishbone classic bus bundle; master drives the request, slave answers.
interface wb_prefetch_buf_if #(
  parameter int unsigned AW = 32
);
  logic          cyc;
  logic          stb;
  logic          we;
  logic [3:0]    sel;
  logic [AW-1:0] adr;
  logic [31:0]   dat_m2s;
  logic [31:0]   dat_s2m;
  logic          ack;

  modport master (output cyc, stb, we, sel, adr, dat_m2s, input  ack, dat_s2m);
  modport slave  (input  cyc, stb, we, sel, adr, dat_m2s, output ack, dat_s2m);
endinterface

// File: rtl/wb_prefetch_buf_fifo.sv
// Prefetch FIFO holding {address, data} pairs; flush has priority over push.
module prefetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [AW-1:0] push_addr,
  input  logic [31:0]   push_data,
  output logic          full,
  output logic          empty,
  output logic [AW-1:0] head_addr,
  output logic [31:0]   head_data
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0] mem_addr [DEPTH];
  logic [31:0]   mem_data [DEPTH];
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [CW-1:0] count_q;
  logic          push_ok;
  logic          pop_ok;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign push_ok   = push & ~full & ~flush;
  assign pop_ok    = pop & ~empty & ~flush;
  assign head_addr = mem_addr[rd_ptr_q];
  assign head_data = mem_data[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Storage needs no reset: entries are only visible through count_q.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_addr[wr_ptr_q] <= push_addr;
      mem_data[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/wb_prefetch_buf.sv
// Wishbone stage in front of the user BRAM: serves sequential reads from a
// prefetch FIFO and forwards misses/writes downstream.
module wb_prefetch_buf
  import wb_prefetch_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter logic [7:0]  REGION = REGION_BASE[31:24],
  parameter int unsigned AW     = 32
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  wb_prefetch_buf_if.slave  wbs,
  wb_prefetch_buf_if.master wbm
);

  state_t        state_q, state_d;
  logic          ack_q, ack_d;
  logic [31:0]   rdat_q, rdat_d;
  logic          cyc_q, cyc_d;
  logic          we_q, we_d;
  logic [3:0]    sel_q, sel_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [31:0]   wdat_q, wdat_d;
  logic [AW-1:0] next_addr_q, next_addr_d;
  logic          armed_q, armed_d;

  logic          push_c, pop_c, flush_c;
  logic          fifo_full, fifo_empty;
  logic [AW-1:0] head_addr;
  logic [31:0]   head_data;

  logic          req_c, rd_req_c, hit_c, match_c, fwd_c, other_c, pref_ok_c;

  prefetch_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .push      (push_c),
    .pop       (pop_c),
    .flush     (flush_c),
    .push_addr (adr_q),
    .push_data (wbm.dat_s2m),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head_addr (head_addr),
    .head_data (head_data)
  );

  // Request qualification; the ack cycle itself never counts as a new request.
  assign req_c     = wbs.cyc & wbs.stb & in_region(32'(wbs.adr), REGION) & ~ack_q;
  assign rd_req_c  = req_c & ~wbs.we;
  assign hit_c     = rd_req_c & ~fifo_empty & (wbs.adr == head_addr);
  assign match_c   = rd_req_c & (wbs.adr == adr_q);
  assign fwd_c     = match_c & fifo_empty;
  assign other_c   = req_c & ~hit_c & ~match_c;
  assign pref_ok_c = armed_q & ~fifo_full & in_region(32'(next_addr_q), REGION);

  always_comb begin
    state_d     = state_q;
    ack_d       = 1'b0;
    rdat_d      = '0;
    cyc_d       = cyc_q;
    we_d        = we_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    wdat_d      = wdat_q;
    next_addr_d = next_addr_q;
    armed_d     = armed_q;
    push_c      = 1'b0;
    pop_c       = 1'b0;
    flush_c     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (hit_c) begin
          pop_c  = 1'b1;
          ack_d  = 1'b1;
          rdat_d = head_data;
        end else if (req_c) begin
          flush_c = 1'b1;
          cyc_d   = 1'b1;
          we_d    = wbs.we;
          sel_d   = wbs.we ? wbs.sel : 4'hF;
          adr_d   = wbs.adr;
          wdat_d  = wbs.we ? wbs.dat_m2s : 32'h0;
          if (wbs.we) begin
            armed_d = 1'b0;
            state_d = WRITE;
          end else begin
            state_d = DEMAND;
          end
        end else if (pref_ok_c) begin
          cyc_d   = 1'b1;
          we_d    = 1'b0;
          sel_d   = 4'hF;
          adr_d   = next_addr_q;
          wdat_d  = '0;
          state_d = PREF;
        end
      end
      DEMAND: begin
        if (wbm.ack) begin
          ack_d       = 1'b1;
          rdat_d      = wbm.dat_s2m;
          next_addr_d = adr_q + AW'(WORD_INC);
          armed_d     = 1'b1;
          state_d     = IDLE;
        end
      end
      WRITE: begin
        if (wbm.ack) begin
          ack_d   = 1'b1;
          state_d = IDLE;
        end
      end
      PREF: begin
        if (wbm.ack) begin
          next_addr_d = adr_q + AW'(WORD_INC);
          armed_d     = 1'b1;
          state_d     = IDLE;
          if (fwd_c) begin
            ack_d  = 1'b1;
            rdat_d = wbm.dat_s2m;
          end else if (other_c) begin
            flush_c = 1'b1;
          end else begin
            push_c = 1'b1;
          end
        end else if (hit_c) begin
          // Hits keep being served while the prefetch is in flight.
          pop_c  = 1'b1;
          ack_d  = 1'b1;
          rdat_d = head_data;
        end else if (other_c) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (wbm.ack) begin
          flush_c = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Any completed downstream access returns the bus to idle.
    if (cyc_q && wbm.ack) begin
      cyc_d  = 1'b0;
      we_d   = 1'b0;
      sel_d  = '0;
      adr_d  = '0;
      wdat_d = '0;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= IDLE;
      ack_q       <= 1'b0;
      rdat_q      <= '0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      wdat_q      <= '0;
      next_addr_q <= '0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      rdat_q      <= rdat_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      wdat_q      <= wdat_d;
      next_addr_q <= next_addr_d;
      armed_q     <= armed_d;
    end
  end

  assign wbs.ack     = ack_q;
  assign wbs.dat_s2m = rdat_q;
  assign wbm.cyc     = cyc_q;
  assign wbm.stb     = cyc_q;
  assign wbm.we      = we_q;
  assign wbm.sel     = sel_q;
  assign wbm.adr     = adr_q;
  assign wbm.dat_m2s = wdat_q;

endmodule

// File: tb/tb_wb_prefetch_buf.sv
// Directed bench for wb_prefetch_buf with a 2-cycle-latency BRAM model.
module tb_wb_prefetch_buf;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  wb_prefetch_buf_if wbs_if ();
  wb_prefetch_buf_if wbm_if ();

  wb_prefetch_buf dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wbs      (wbs_if),
    .wbm      (wbm_if)
  );

  int checks   = 0;
  int failures = 0;

  function automatic logic [31:0] word_init(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  // BRAM model: ack two cycles after stb, small table of written words.
  logic [31:0] wr_adr [8];
  logic [31:0] wr_dat [8];
  int          wr_n     = 0;
  int          wait_cnt = 0;

  function automatic logic [31:0] bram_read(input logic [31:0] a);
    logic [31:0] d;
    d = word_init(a);
    for (int k = 0; k < 8; k++)
      if (k < wr_n && wr_adr[k] == a) d = wr_dat[k];
    return d;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt       <= 0;
      wbm_if.ack     <= 1'b0;
      wbm_if.dat_s2m <= '0;
    end else begin
      wbm_if.ack <= 1'b0;
      if (wbm_if.cyc && wbm_if.stb && !wbm_if.ack) begin
        if (wait_cnt == 1) begin
          wait_cnt   <= 0;
          wbm_if.ack <= 1'b1;
          if (wbm_if.we) begin
            wr_adr[wr_n % 8] <= wbm_if.adr;
            wr_dat[wr_n % 8] <= wbm_if.dat_m2s;
            wr_n             <= wr_n + 1;
            wbm_if.dat_s2m   <= '0;
          end else begin
            wbm_if.dat_s2m <= bram_read(wbm_if.adr);
          end
        end else begin
          wait_cnt <= wait_cnt + 1;
        end
      end else begin
        wait_cnt <= 0;
      end
    end
  end

  // Downstream monitor.
  int          ds_cnt      = 0;
  logic [31:0] ds_last_adr = '0;
  logic        ds_last_we  = 1'b0;
  int          oob_cnt     = 0;
  int          stb_bad     = 0;

  always @(posedge clk) begin
    if (!rst) begin
      if (wbm_if.cyc && wbm_if.ack) begin
        ds_cnt      <= ds_cnt + 1;
        ds_last_adr <= wbm_if.adr;
        ds_last_we  <= wbm_if.we;
      end
      if (wbm_if.cyc && wbm_if.adr[31:24] != 8'h38) oob_cnt <= oob_cnt + 1;
      if (wbm_if.stb != wbm_if.cyc) stb_bad <= stb_bad + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold one upstream request until acked or the budget expires (lat=0).
  task automatic run_req(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                         input int budget, output int lat, output logic [31:0] dat);
    bit done;
    lat  = 0;
    dat  = '0;
    done = 1'b0;
    wbs_if.cyc     = 1'b1;
    wbs_if.stb     = 1'b1;
    wbs_if.we      = we;
    wbs_if.sel     = 4'hF;
    wbs_if.adr     = adr;
    wbs_if.dat_m2s = wdat;
    for (int n = 1; n <= budget; n++) begin
      if (!done) begin
        tick();
        if (wbs_if.ack) begin
          lat  = n;
          dat  = wbs_if.dat_s2m;
          done = 1'b1;
        end
      end
    end
    wbs_if.cyc = 1'b0;
    wbs_if.stb = 1'b0;
    wbs_if.we  = 1'b0;
  endtask

  typedef struct {
    int          idle;
    logic [31:0] adr;
    logic        we;
    logic [31:0] wdat;
    int          lat;
    logic [31:0] dat;
    int          settle;
    int          nds;
    logic [31:0] last;
    logic        last_we;
  } vec_t;

  localparam int NV = 9;
  vec_t vec [NV];

  initial begin
    int          lat;
    int          ds0;
    logic [31:0] rdat;

    // cold miss, then four prefetches fill the FIFO
    vec[0] = '{idle:2,  adr:32'h3800_0000, we:1'b0, wdat:'0, lat:4, dat:word_init(32'h3800_0000),
               settle:24, nds:5, last:32'h3800_0010, last_we:1'b0};
    vec[1] = '{idle:1,  adr:32'h3800_0004, we:1'b0, wdat:'0, lat:1, dat:word_init(32'h3800_0004),
               settle:0,  nds:0, last:'0, last_we:1'b0};
    vec[2] = '{idle:1,  adr:32'h3800_0008, we:1'b0, wdat:'0, lat:1, dat:word_init(32'h3800_0008),
               settle:16, nds:2, last:32'h3800_0018, last_we:1'b0};
    // write flushes; no prefetch follows
    vec[3] = '{idle:1,  adr:32'h3800_0008, we:1'b1, wdat:32'hDEAD_BEEF, lat:4, dat:'0,
               settle:8,  nds:1, last:32'h3800_0008, last_we:1'b1};
    // settle of 8 lands the next request during the 0x14 prefetch
    vec[4] = '{idle:1,  adr:32'h3800_0008, we:1'b0, wdat:'0, lat:4, dat:32'hDEAD_BEEF,
               settle:8,  nds:3, last:32'h3800_0010, last_we:1'b0};
    vec[5] = '{idle:0,  adr:32'h3800_0100, we:1'b0, wdat:'0, lat:7, dat:word_init(32'h3800_0100),
               settle:0,  nds:2, last:32'h3800_0100, last_we:1'b0};
    // region end: only 0x38FF_FFFC is prefetched
    vec[6] = '{idle:20, adr:32'h38FF_FFF8, we:1'b0, wdat:'0, lat:4, dat:word_init(32'h38FF_FFF8),
               settle:12, nds:2, last:32'h38FF_FFFC, last_we:1'b0};
    vec[7] = '{idle:1,  adr:32'h3000_0000, we:1'b0, wdat:'0, lat:0, dat:'0,
               settle:4,  nds:0, last:'0, last_we:1'b0};
    vec[8] = '{idle:1,  adr:32'h3800_0020, we:1'b0, wdat:'0, lat:4, dat:word_init(32'h3800_0020),
               settle:24, nds:5, last:32'h3800_0030, last_we:1'b0};

    wbs_if.cyc = 1'b0; wbs_if.stb = 1'b0; wbs_if.we = 1'b0;
    wbs_if.sel = '0;   wbs_if.adr = '0;   wbs_if.dat_m2s = '0;

    #1 rst = 1'b1;
    #2;
    check("rst_ack",     32'(wbs_if.ack),  32'h0);
    check("rst_dat",     wbs_if.dat_s2m,   32'h0);
    check("rst_wbm_cyc", 32'(wbm_if.cyc),  32'h0);
    check("rst_wbm_adr", wbm_if.adr,       32'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      repeat (vec[i].idle) tick();
      ds0 = ds_cnt;
      run_req(vec[i].adr, vec[i].we, vec[i].wdat, (vec[i].lat == 0) ? 10 : 12, lat, rdat);
      check($sformatf("v%0d_lat", i), 32'(lat), 32'(vec[i].lat));
      if (!vec[i].we && vec[i].lat != 0)
        check($sformatf("v%0d_dat", i), rdat, vec[i].dat);
      if (lat != 0) begin
        tick();
        check($sformatf("v%0d_ack_pulse", i), 32'(wbs_if.ack), 32'h0);
        check($sformatf("v%0d_dat_idle", i),  wbs_if.dat_s2m,   32'h0);
      end
      repeat (vec[i].settle) tick();
      check($sformatf("v%0d_ds_count", i), 32'(ds_cnt - ds0), 32'(vec[i].nds));
      if (vec[i].nds != 0) begin
        check($sformatf("v%0d_ds_last_adr", i), ds_last_adr,     vec[i].last);
        check($sformatf("v%0d_ds_last_we", i),  32'(ds_last_we), 32'(vec[i].last_we));
      end
    end

    // Reset during an outstanding demand read.
    tick();
    wbs_if.cyc = 1'b1; wbs_if.stb = 1'b1; wbs_if.we = 1'b0;
    wbs_if.sel = 4'hF; wbs_if.adr = 32'h3800_0040;
    tick();
    check("mid_demand_cyc", 32'(wbm_if.cyc), 32'h1);
    check("mid_demand_adr", wbm_if.adr,      32'h3800_0040);
    tick();
    rst = 1'b1;
    #1;
    check("rst_drop_cyc", 32'(wbm_if.cyc), 32'h0);
    check("rst_drop_ack", 32'(wbs_if.ack), 32'h0);
    wbs_if.cyc = 1'b0; wbs_if.stb = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // 0x24 was buffered before reset; it must now miss.
    ds0 = ds_cnt;
    run_req(32'h3800_0024, 1'b0, '0, 12, lat, rdat);
    check("post_rst_lat", 32'(lat), 32'h4);
    check("post_rst_dat", rdat, word_init(32'h3800_0024));
    check("post_rst_ds_count", 32'(ds_cnt - ds0), 32'h1);
    check("post_rst_ds_adr", ds_last_adr, 32'h3800_0024);
    tick();

    check("out_of_region_wbm", 32'(oob_cnt), 32'h0);
    check("stb_equals_cyc",    32'(stb_bad), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
